// File: rtl/lsu_cache_req.sv
// MEM-stage to data-cache request initiator: formats RV32 loads/stores into word-aligned cache requests.
// Optional feature macro LSU_MISALIGN_EXC_EN: misaligned H/W accesses complete at once with lsu_misalign_o set.
module lsu_cache_req #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid_i,
  input  logic              mem_we_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_misalign_o,
  output logic              cpu_rd_req_o,
  output logic              cpu_wr_req_o,
  output logic [ADDR_W-1:0] cpu_rd_addr_o,
  output logic [ADDR_W-1:0] cpu_wr_addr_o,
  output logic [DATA_W-1:0] cpu_wr_data_o,
  output logic [3:0]        cpu_wr_en_o,
  input  logic [DATA_W-1:0] cpu_rd_data_i,
  input  logic              pipeline_stall_i,
  input  logic              cache_data_ack_i
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wr_en_q, wr_en_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] st_data;
  logic [3:0]        st_en;
  logic [DATA_W-1:0] ld_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              accept;

  always_comb begin
    st_data = mem_wdata_i;
    st_en   = 4'b1111;
    case (mem_funct3_i)
      3'b000: begin
        st_en   = 4'b0001 << mem_addr_i[1:0];
        st_data = {4{mem_wdata_i[7:0]}};
      end
      3'b001: begin
        st_en   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        st_data = {2{mem_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the funct3 and byte lane captured at accept time.
  always_comb begin
    ld_byte = cpu_rd_data_i[7:0];
    case (lane_q)
      2'd1:    ld_byte = cpu_rd_data_i[15:8];
      2'd2:    ld_byte = cpu_rd_data_i[23:16];
      2'd3:    ld_byte = cpu_rd_data_i[31:24];
      default: ld_byte = cpu_rd_data_i[7:0];
    endcase
    ld_half = lane_q[1] ? cpu_rd_data_i[31:16] : cpu_rd_data_i[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = cpu_rd_data_i;
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic misalign_q, misalign_d;
  logic misaligned;
  assign misaligned = ((mem_funct3_i[1:0] == 2'b01) && mem_addr_i[0]) ||
                      ((mem_funct3_i[1:0] == 2'b10) && (mem_addr_i[1:0] != 2'b00));
  assign accept         = mem_valid_i && !misaligned;
  assign lsu_misalign_o = misalign_q;
`else
  assign accept         = mem_valid_i;
  assign lsu_misalign_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_en_d  = wr_en_q;
    funct3_d = funct3_q;
    lane_d   = lane_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_WAIT;
          rd_req_d = !mem_we_i;
          wr_req_d = mem_we_i;
          addr_d   = {mem_addr_i[ADDR_W-1:2], 2'b00};
          wdata_d  = st_data;
          wr_en_d  = st_en;
          funct3_d = mem_funct3_i;
          lane_d   = mem_addr_i[1:0];
        end
`ifdef LSU_MISALIGN_EXC_EN
        else if (mem_valid_i) begin
          done_d     = 1'b1;
          misalign_d = 1'b1;
          rdata_d    = '0;
        end
`endif
      end
      ST_WAIT: begin
        if (cache_data_ack_i) begin
          state_d  = ST_IDLE;
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          done_d   = 1'b1;
          rdata_d  = wr_req_q ? '0 : ld_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_en_q  <= '0;
      funct3_q <= '0;
      lane_q   <= '0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
`ifdef LSU_MISALIGN_EXC_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_en_q  <= wr_en_d;
      funct3_q <= funct3_d;
      lane_q   <= lane_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
`ifdef LSU_MISALIGN_EXC_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign lsu_busy_o    = (state_q == ST_WAIT) || pipeline_stall_i;
  assign lsu_done_o    = done_q;
  assign lsu_rdata_o   = rdata_q;
  assign cpu_rd_req_o  = rd_req_q;
  assign cpu_wr_req_o  = wr_req_q;
  assign cpu_rd_addr_o = addr_q;
  assign cpu_wr_addr_o = addr_q;
  assign cpu_wr_data_o = wdata_q;
  assign cpu_wr_en_o   = wr_en_q;

endmodule

// File: tb/tb_lsu_cache_req.sv
// Directed bench for lsu_cache_req: vector table of single accesses plus multi-cycle sequences.
module tb_lsu_cache_req;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [2:0]  mem_funct3_i = 3'd0;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] mem_wdata_i = 32'd0;
  logic        lsu_busy_o;
  logic        lsu_done_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_misalign_o;
  logic        cpu_rd_req_o;
  logic        cpu_wr_req_o;
  logic [31:0] cpu_rd_addr_o;
  logic [31:0] cpu_wr_addr_o;
  logic [31:0] cpu_wr_data_o;
  logic [3:0]  cpu_wr_en_o;
  logic [31:0] cpu_rd_data_i = 32'd0;
  logic        pipeline_stall_i = 1'b0;
  logic        cache_data_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  lsu_cache_req #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_funct3_i(mem_funct3_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_misalign_o(lsu_misalign_o),
    .cpu_rd_req_o(cpu_rd_req_o), .cpu_wr_req_o(cpu_wr_req_o),
    .cpu_rd_addr_o(cpu_rd_addr_o), .cpu_wr_addr_o(cpu_wr_addr_o),
    .cpu_wr_data_o(cpu_wr_data_o), .cpu_wr_en_o(cpu_wr_en_o),
    .cpu_rd_data_i(cpu_rd_data_i), .pipeline_stall_i(pipeline_stall_i),
    .cache_data_ack_i(cache_data_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic [31:0] expAddr;
    logic [3:0]  expEn;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    mem_valid_i  = 1'b1;
    mem_we_i     = we;
    mem_funct3_i = f3;
    mem_addr_i   = addr;
    mem_wdata_i  = wdata;
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v.we, v.funct3, v.addr, v.wdata);
    step();
    mem_valid_i = 1'b0;
    checkOutput("busy_wait", {31'd0, lsu_busy_o}, 32'd1);
    checkOutput("rd_req", {31'd0, cpu_rd_req_o}, {31'd0, ~v.we});
    checkOutput("wr_req", {31'd0, cpu_wr_req_o}, {31'd0, v.we});
    if (v.we) begin
      checkOutput("wr_addr", cpu_wr_addr_o, v.expAddr);
      checkOutput("wr_en", {28'd0, cpu_wr_en_o}, {28'd0, v.expEn});
      checkOutput("wr_data", cpu_wr_data_o, v.expWdata);
    end else begin
      checkOutput("rd_addr", cpu_rd_addr_o, v.expAddr);
    end
    cache_data_ack_i = 1'b1;
    cpu_rd_data_i    = v.rword;
    step();
    cache_data_ack_i = 1'b0;
    cpu_rd_data_i    = 32'hDEAD_0000;
    checkOutput("done_pulse", {31'd0, lsu_done_o}, 32'd1);
    checkOutput("req_drop", {30'd0, cpu_rd_req_o, cpu_wr_req_o}, 32'd0);
    checkOutput("rdata", lsu_rdata_o, v.expRdata);
    checkOutput("misalign_0", {31'd0, lsu_misalign_o}, 32'd0);
    step();
    checkOutput("done_clear", {31'd0, lsu_done_o}, 32'd0);
    checkOutput("rdata_hold", lsu_rdata_o, v.expRdata);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[1]  = '{1'b1, 3'b000, 32'h1001, 32'h0000_003C, 32'h0, 32'h1000, 4'b0010, 32'h3C3C_3C3C, 32'h0};
    vecs[2]  = '{1'b1, 3'b001, 32'h1002, 32'h1234_BEEF, 32'h0, 32'h1000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[3]  = '{1'b1, 3'b001, 32'h1000, 32'h1234_BEEF, 32'h0, 32'h1000, 4'b0011, 32'hBEEF_BEEF, 32'h0};
    vecs[4]  = '{1'b1, 3'b010, 32'h1008, 32'hDEAD_BEEF, 32'h0, 32'h1008, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[5]  = '{1'b1, 3'b111, 32'h100C, 32'h0102_0304, 32'h0, 32'h100C, 4'b1111, 32'h0102_0304, 32'h0};
    vecs[6]  = '{1'b0, 3'b000, 32'h2001, 32'h0, 32'h0000_8000, 32'h2000, 4'b0, 32'h0, 32'hFFFF_FF80};
    vecs[7]  = '{1'b0, 3'b100, 32'h2001, 32'h0, 32'h0000_8000, 32'h2000, 4'b0, 32'h0, 32'h0000_0080};
    vecs[8]  = '{1'b0, 3'b001, 32'h2002, 32'h0, 32'h8001_0000, 32'h2000, 4'b0, 32'h0, 32'hFFFF_8001};
    vecs[9]  = '{1'b0, 3'b101, 32'h2002, 32'h0, 32'h8001_0000, 32'h2000, 4'b0, 32'h0, 32'h0000_8001};
    vecs[10] = '{1'b0, 3'b010, 32'h2004, 32'h0, 32'hCAFE_F00D, 32'h2004, 4'b0, 32'h0, 32'hCAFE_F00D};
    vecs[11] = '{1'b0, 3'b000, 32'h2003, 32'h0, 32'h7F00_0000, 32'h2000, 4'b0, 32'h0, 32'h0000_007F};
    vecs[12] = '{1'b0, 3'b100, 32'h2000, 32'h0, 32'h1234_56FF, 32'h2000, 4'b0, 32'h0, 32'h0000_00FF};
    vecs[13] = '{1'b0, 3'b001, 32'h2000, 32'h0, 32'h0001_7FFE, 32'h2000, 4'b0, 32'h0, 32'h0000_7FFE};
    vecs[14] = '{1'b0, 3'b011, 32'h2008, 32'h0, 32'h1122_3344, 32'h2008, 4'b0, 32'h0, 32'h1122_3344};

    #12;
    checkOutput("reset_outs", {lsu_busy_o, lsu_done_o, lsu_misalign_o, cpu_rd_req_o, cpu_wr_req_o, cpu_wr_en_o},
                32'd0);
    checkOutput("reset_rdata", lsu_rdata_o, 32'd0);
    checkOutput("reset_addr", cpu_rd_addr_o | cpu_wr_addr_o | cpu_wr_data_o, 32'd0);
    rst_n = 1'b1;
    step();

    pipeline_stall_i = 1'b1;
    #1;
    checkOutput("busy_stall", {31'd0, lsu_busy_o}, 32'd1);
    pipeline_stall_i = 1'b0;
    #1;
    checkOutput("busy_idle", {31'd0, lsu_busy_o}, 32'd0);

    cache_data_ack_i = 1'b1;
    step();
    cache_data_ack_i = 1'b0;
    checkOutput("idle_ack_ignored", {29'd0, lsu_done_o, cpu_rd_req_o, cpu_wr_req_o}, 32'd0);
    step();

    for (int i = 0; i < 15; i++) runVector(vecs[i]);

    // Delayed ack: request and fields held five cycles, new valid ignored meanwhile
    applyStimulus(1'b0, 3'b001, 32'h2002, 32'h0);
    step();
    applyStimulus(1'b1, 3'b010, 32'h5554, 32'hFFFF_FFFF);
    for (int c = 0; c < 5; c++) begin
      checkOutput("hold_rd_req", {31'd0, cpu_rd_req_o}, 32'd1);
      checkOutput("hold_wr_req", {31'd0, cpu_wr_req_o}, 32'd0);
      checkOutput("hold_busy", {31'd0, lsu_busy_o}, 32'd1);
      checkOutput("hold_addr", cpu_rd_addr_o, 32'h2000);
      checkOutput("hold_done", {31'd0, lsu_done_o}, 32'd0);
      step();
    end
    mem_valid_i      = 1'b0;
    cache_data_ack_i = 1'b1;
    cpu_rd_data_i    = 32'h8001_0000;
    step();
    cache_data_ack_i = 1'b0;
    checkOutput("delay_done", {31'd0, lsu_done_o}, 32'd1);
    checkOutput("delay_rdata", lsu_rdata_o, 32'hFFFF_8001);
    step();

    // Back-to-back SW then LW to the same word
    applyStimulus(1'b1, 3'b010, 32'h3000, 32'h55AA_1234);
    step();
    mem_valid_i = 1'b0;
    checkOutput("b2b_wr_req", {31'd0, cpu_wr_req_o}, 32'd1);
    cache_data_ack_i = 1'b1;
    step();
    cache_data_ack_i = 1'b0;
    checkOutput("b2b_done1", {31'd0, lsu_done_o}, 32'd1);
    checkOutput("b2b_wr_rdata", lsu_rdata_o, 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h3000, 32'h0);
    step();
    mem_valid_i = 1'b0;
    checkOutput("b2b_rd_req", {31'd0, cpu_rd_req_o}, 32'd1);
    checkOutput("b2b_no_wr", {31'd0, cpu_wr_req_o}, 32'd0);
    checkOutput("b2b_done1_clear", {31'd0, lsu_done_o}, 32'd0);
    checkOutput("b2b_rd_addr", cpu_rd_addr_o, 32'h3000);
    cache_data_ack_i = 1'b1;
    cpu_rd_data_i    = 32'h55AA_1234;
    step();
    cache_data_ack_i = 1'b0;
    checkOutput("b2b_done2", {31'd0, lsu_done_o}, 32'd1);
    checkOutput("b2b_rdata", lsu_rdata_o, 32'h55AA_1234);
    step();

    // Reset during WAIT
    applyStimulus(1'b0, 3'b010, 32'h2004, 32'h0);
    step();
    mem_valid_i = 1'b0;
    checkOutput("pre_rst_req", {31'd0, cpu_rd_req_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req_drop", {30'd0, cpu_rd_req_o, cpu_wr_req_o}, 32'd0);
    checkOutput("rst_no_done", {31'd0, lsu_done_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, lsu_busy_o}, 32'd0);
    cache_data_ack_i = 1'b1;
    step();
    checkOutput("rst_held_no_done", {31'd0, lsu_done_o}, 32'd0);
    cache_data_ack_i = 1'b0;
    rst_n = 1'b1;
    step();
    runVector(vecs[10]);

    // Misaligned word load
    applyStimulus(1'b0, 3'b010, 32'h4002, 32'h0);
    step();
    mem_valid_i = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    checkOutput("mis_no_req", {30'd0, cpu_rd_req_o, cpu_wr_req_o}, 32'd0);
    checkOutput("mis_done", {31'd0, lsu_done_o}, 32'd1);
    checkOutput("mis_flag", {31'd0, lsu_misalign_o}, 32'd1);
    checkOutput("mis_rdata", lsu_rdata_o, 32'd0);
    step();
    checkOutput("mis_clear", {30'd0, lsu_done_o, lsu_misalign_o}, 32'd0);
`else
    checkOutput("mis_rd_req", {31'd0, cpu_rd_req_o}, 32'd1);
    checkOutput("mis_addr", cpu_rd_addr_o, 32'h4000);
    checkOutput("mis_flag0", {31'd0, lsu_misalign_o}, 32'd0);
    cache_data_ack_i = 1'b1;
    cpu_rd_data_i    = 32'h0BAD_F00D;
    step();
    cache_data_ack_i = 1'b0;
    checkOutput("mis_done", {31'd0, lsu_done_o}, 32'd1);
    checkOutput("mis_rdata", lsu_rdata_o, 32'h0BAD_F00D);
    checkOutput("mis_flag_done", {31'd0, lsu_misalign_o}, 32'd0);
`endif
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Exclusive-request check runs on every falling edge throughout the test.
  always @(negedge clk) begin
    if (cpu_rd_req_o && cpu_wr_req_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_exclusive: got rd=%0b wr=%0b, expected not both 1", cpu_rd_req_o, cpu_wr_req_o);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
